// File: rtl/fetch_sequencer.sv
// fetch_sequencer
//   Sequences reads of a word-addressed, asynchronous-read instruction memory.
//   Holds the PC, hands one registered instruction per cycle to decode over a
//   valid/ready handshake, accepts branch/jump redirects and halts after the
//   fetch of LAST_PC.
//
// Ports
//   clk            in   clock, rising edge
//   rst            in   synchronous reset, active-high
//   start          in   pulse: begin fetching at RESET_PC (honoured in IDLE/HALT)
//   imem_addr      out  instruction memory address (always the PC register)
//   imem_rdata     in   instruction memory read data for imem_addr, same cycle
//   instr_out      out  registered instruction presented to decode
//   instr_pc       out  address instr_out was fetched from
//   instr_valid    out  instr_out / instr_pc valid
//   instr_ready    in   decode accepts instr_out this cycle
//   redirect_valid in   branch/jump taken: flush the held word and refetch
//   redirect_pc    in   redirect target
//   busy           out  1 while in RUN
//   halted         out  1 while in HALT
//   fetch_count    out  instructions accepted by decode since start, saturating

module fetch_sequencer #(
   parameter int unsigned       ADDR_W   = 32,
   parameter int unsigned       DATA_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = '0,
   parameter logic [ADDR_W-1:0] LAST_PC  = ADDR_W'(11)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic [DATA_W-1:0] imem_rdata,
   output logic [DATA_W-1:0] instr_out,
   output logic [ADDR_W-1:0] instr_pc,
   output logic              instr_valid,
   input  logic              instr_ready,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic              busy,
   output logic              halted,
   output logic [15:0]       fetch_count
);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      HALT
   } state_t;

   state_t              state_q;
   state_t              state_d;

   logic [ADDR_W-1:0]   pc_q;
   logic [DATA_W-1:0]   instr_q;
   logic [ADDR_W-1:0]   ipc_q;
   logic                valid_q;
   logic [15:0]         count_q;

   logic                take_start;
   logic                take_redirect;
   logic                load;
   logic                xfer;
   logic                last_load;

   // ------------------------------------------------------------------
   // Control decode
   // ------------------------------------------------------------------
   always_comb begin
      take_start    = (state_q != RUN) && start;
      take_redirect = (state_q == RUN) && redirect_valid;
      // The output register may be refilled when empty or being drained.
      load          = (state_q == RUN) && (!valid_q || instr_ready);
      xfer          = valid_q && instr_ready;
      // A redirect in the same cycle as the final load overrides the halt.
      last_load     = load && !take_redirect && (pc_q == LAST_PC);
   end

   // ------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ------------------------------------------------------------------
   // FSM: next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (take_start) begin
               state_d = RUN;
            end
         end
         RUN: begin
            if (last_load) begin
               state_d = HALT;
            end
         end
         HALT: begin
            if (take_start) begin
               state_d = RUN;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // FSM: outputs
   // ------------------------------------------------------------------
   always_comb begin
      busy   = (state_q == RUN);
      halted = (state_q == HALT);
   end

   // ------------------------------------------------------------------
   // Datapath: PC, output register, accepted-instruction counter
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q    <= RESET_PC;
         instr_q <= '0;
         ipc_q   <= '0;
         valid_q <= 1'b0;
         count_q <= '0;
      end else if (take_start) begin
         // Start outranks a redirect presented in HALT; the held word, if
         // any, is dropped without a handshake.
         pc_q    <= RESET_PC;
         valid_q <= 1'b0;
         count_q <= '0;
      end else begin
         // A transfer is counted even in a cycle that also flushes.
         if (xfer && (count_q != 16'hFFFF)) begin
            count_q <= count_q + 16'd1;
         end

         if (take_redirect) begin
            pc_q    <= redirect_pc;
            valid_q <= 1'b0;
         end else if (load) begin
            instr_q <= imem_rdata;
            ipc_q   <= pc_q;
            valid_q <= 1'b1;
            pc_q    <= pc_q + ADDR_W'(1);
         end else if (xfer) begin
            // Only reachable outside RUN: drain the last word after a halt.
            valid_q <= 1'b0;
         end
      end
   end

   assign imem_addr   = pc_q;
   assign instr_out   = instr_q;
   assign instr_pc    = ipc_q;
   assign instr_valid = valid_q;
   assign fetch_count = count_q;

endmodule
